alu_ctrl: RTL and testbench
===========================

Name: alu_ctrl

Overview:
Sequencing controller wrapped around the combinational 16-bit ALU.
- Accepts one operation at a time over a valid/ready request channel.
- Dispatches logic, pass-through and mod-free ops to the external ALU through its `alu_op`/`alu_a`/`alu_b` ports.
- Executes add/sub in one cycle and mul/div/mod iteratively, in-block.
- Owns the persistent carry flag, including clr_c/set_c.
- Returns the result plus CCR over a valid/ready response channel.

Parameters:
- `W`, 16, datapath width (operands, result, hi word).
- `ITER`, 16, mul/div iterations; must equal `W`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept.
- `req_op`  in  4  opcode, per shared ALU op encoding.
- `req_a`  in  16  operand A.
- `req_b`  in  16  operand B.
- `alu_op`  out  4  opcode driven to the ALU.
- `alu_a`  out  16  ALU operand A.
- `alu_b`  out  16  ALU operand B.
- `alu_res`  in  16  signed ALU result.
- `alu_ccr`  in  4  ALU flags; bit3 = N, bit2 = Z.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  16  result (low word / quotient / remainder).
- `rsp_hi`  out  16  mul high word; div remainder; else 0.
- `rsp_ccr`  out  4  {N, Z, V, C}.
- `rsp_err`  out  1  divide-by-zero or illegal opcode.

Behaviour:
- Reset:
  - state = IDLE.
  - `rsp_valid`, `rsp_data`, `rsp_hi`, `rsp_ccr`, `rsp_err` = 0.
  - carry register = 0.
  - `alu_op` = nop_a; `alu_a`/`alu_b` = 0.
  - Reset mid-operation discards the in-flight op; no response is produced.
- States:
  - IDLE: `req_ready` = 1. Accept on `req_valid` and `req_ready`; latch op/A/B.
    - mul/div/mod with B ≠ 0 → ITER.
    - All other ops → EXEC.
  - EXEC: one cycle; compute the result → DONE.
  - ITER: `ITER` cycles of a shift-add multiply or restoring divide; counter counts down from `ITER`-1 → DONE.
  - DONE: `rsp_valid` = 1. Outputs are held stable until `rsp_ready`, then → IDLE.
- `req_ready` is high only in IDLE, so there is no request/response overlap.
- Latency from the accept edge to `rsp_valid` high:
  - EXEC path: 2 edges.
  - ITER path: `ITER` + 1 = 17 edges.
- ALU ops (nop_a, nop_b, not_a, and, or, xor):
  - Latched operands and op are driven to the ALU during EXEC.
  - `alu_res` is captured; N and Z are taken from `alu_ccr`.
  - V = 0; C is unchanged.
- Outside EXEC, the ALU-facing ports hold their last values.
- add/sub (in-block, 17-bit):
  - C = carry-out for add; C = borrow for sub.
  - V = signed overflow.
  - N = `rsp_data[15]`; Z = (`rsp_data` == 0).
- mul:
  - Unsigned 16×16 → 32 bits; `rsp_data` = low word, `rsp_hi` = high word.
  - V = (`rsp_hi` ≠ 0); N/Z from `rsp_data`; C unchanged.
- div/mod:
  - Unsigned.
  - div: `rsp_data` = quotient, `rsp_hi` = remainder.
  - mod: `rsp_data` = remainder, `rsp_hi` = 0.
  - B == 0: EXEC path; `rsp_data` = 0xFFFF (div) or A (mod); `rsp_err` = 1; V = 1.
- clr_c/set_c:
  - Carry ← 0 / 1.
  - `rsp_data` = A; N/Z from A.
- Illegal opcodes 1101–1111: EXEC path; `rsp_data` = 0; `rsp_err` = 1; flags: Z = 1, others 0, C preserved.
- `rsp_ccr` bit0 always reflects the carry register after the op.

Optional Feature:
- Macro: `ALU_CTRL_PERF_CNT_EN`.
- With the macro defined, two extra outputs are present:
  - `perf_ops` [31:0]: increments on every response handshake.
  - `perf_busy` [31:0]: increments every cycle state ≠ IDLE.
  - Both counters wrap at 2^32 and clear on `rst`.
- Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package `alu_pkg` holds:
  - the 4-bit opcode constants (nop_a = 0000 … set_c = 1100);
  - CCR bit indices (N = 3, Z = 2, V = 1, C = 0);
  - the controller state enum (IDLE, EXEC, ITER, DONE).
- One sub-module, `alu_ctrl_muldiv`:
  - iterative shift-add multiplier / restoring divider;
  - start/busy/done interface, 16 cycles per operation.
- The ALU itself is instantiated by the parent, not inside `alu_ctrl`.

Test Plan:
1. xor, A = 0x00FF, B = 0x0F0F:
   - During EXEC: `alu_op` = 0101.
   - `rsp_data` = 0x0FF0, `rsp_ccr` = 0000, `rsp_valid` 2 edges after accept.
2. add, 0x7FFF + 0x0001 → `rsp_data` = 0x8000, `rsp_ccr` = 1010. Then sub, 0x0000 − 0x0001 → `rsp_data` = 0xFFFF, `rsp_ccr` = 1001.
3. mul, 0x1234 × 0x0100:
   - `rsp_data` = 0x3400, `rsp_hi` = 0x0012, `rsp_ccr` = 0010.
   - `rsp_valid` exactly 17 edges after accept.
4. Divide cases:
   - div 100/7 → `rsp_data` = 0x000E, `rsp_hi` = 0x0002.
   - mod 100/7 → `rsp_data` = 0x0002.
   - div 5/0 → `rsp_data` = 0xFFFF, `rsp_err` = 1, 2-edge latency.
5. Carry flag:
   - set_c → `rsp_ccr`[0] = 1.
   - Following xor 0xFFFF ^ 0xFFFF → `rsp_ccr` = 0101.
   - clr_c → `rsp_ccr`[0] = 0.
6. Reset and backpressure:
   - Assert `rst` during ITER cycle 5 → `rsp_valid` = 0 and `req_ready` = 1 immediately, no response emitted.
   - Separately, hold `rsp_ready` = 0 for 10 cycles in DONE → all `rsp_*` stable and `req_ready` = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, CCR bit indices and controller state for the ALU sequencer
package alu_pkg;

    localparam logic [3:0] OP_NOP_A = 4'b0000;
    localparam logic [3:0] OP_NOP_B = 4'b0001;
    localparam logic [3:0] OP_NOT_A = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_ADD   = 4'b0110;
    localparam logic [3:0] OP_SUB   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_DIV   = 4'b1001;
    localparam logic [3:0] OP_MOD   = 4'b1010;
    localparam logic [3:0] OP_CLR_C = 4'b1011;
    localparam logic [3:0] OP_SET_C = 4'b1100;

    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_ITER,
        ST_DONE
    } ctrl_state_t;

    // Ops that the external combinational ALU evaluates for us.
    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_XOR;
    endfunction

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// rtl/alu_ctrl_if.sv - request/response channels and ALU-facing bus of the ALU sequencer
interface alu_ctrl_if #(
    parameter int W = 16
);
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;

    logic [3:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_res;
    logic [3:0]   alu_ccr;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [W-1:0] rsp_hi;
    logic [3:0]   rsp_ccr;
    logic         rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_res, alu_ccr, rsp_ready,
        output req_ready, alu_op, alu_a, alu_b,
        output rsp_valid, rsp_data, rsp_hi, rsp_ccr, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_res, alu_ccr, rsp_ready,
        input  req_ready, alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_data, rsp_hi, rsp_ccr, rsp_err
    );
endinterface

// File: rtl/alu_ctrl_muldiv.sv
// rtl/alu_ctrl_muldiv.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
module alu_ctrl_muldiv #(
    parameter int W    = 16,
    parameter int ITER = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] res_lo,
    output logic [W-1:0] res_hi
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    logic [CW-1:0] cnt;
    logic          div_q;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  m;
    logic [W-1:0]  hi_nxt;
    logic [W-1:0]  lo_nxt;
    logic [W:0]    sum;
    logic [W:0]    trial;
    logic [W:0]    diff;
    logic          fits;

    // mul: {hi,lo} is the running product with the multiplier shifting out of lo.
    // div: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        trial  = {hi, lo[W-1]};
        diff   = trial - {1'b0, m};
        fits   = (trial >= {1'b0, m});
        hi_nxt = sum[W:1];
        lo_nxt = {sum[0], lo[W-1:1]};
        if (div_q) begin
            hi_nxt = fits ? diff[W-1:0] : trial[W-1:0];
            lo_nxt = {lo[W-2:0], fits};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            div_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            m     <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CW'(ITER - 1);
            div_q <= is_div;
            hi    <= '0;
            lo    <= a;
            m     <= b;
        end else if (busy) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // The final step's result is presented combinationally so the caller can register it on the same edge.
    assign done   = busy && (cnt == '0);
    assign res_lo = lo_nxt;
    assign res_hi = hi_nxt;

endmodule

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - sequencing controller around the external 16-bit ALU, owns the carry flag
// Optional ALU_CTRL_PERF_CNT_EN adds perf_ops / perf_busy counters.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int W    = 16,
    parameter int ITER = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_ctrl_if.slave  bus
`ifdef ALU_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_busy
`endif
);
    ctrl_state_t  state;
    logic [3:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         carry;

    logic         rsp_valid_q;
    logic [W-1:0] rsp_data_q;
    logic [W-1:0] rsp_hi_q;
    logic [3:0]   rsp_ccr_q;
    logic         rsp_err_q;
    logic [3:0]   alu_op_q;
    logic [W-1:0] alu_a_q;
    logic [W-1:0] alu_b_q;

    logic         accept;
    logic         iter_start;
    logic         md_busy;
    logic         md_done;
    logic [W-1:0] md_lo;
    logic [W-1:0] md_hi;

    logic [W-1:0] x_data;
    logic [W-1:0] x_hi;
    logic [3:0]   x_ccr;
    logic         x_v;
    logic         x_err;
    logic         x_use_alu_flags;
    logic         c_nxt;
    logic [W:0]   sum17;
    logic [W:0]   dif17;
    logic [1:0]   unused_alu_vc;
    logic         unused_md_busy;

    assign accept     = bus.req_valid && (state == ST_IDLE);
    assign iter_start = accept && is_iter_op(bus.req_op) && (bus.req_b != '0);

    alu_ctrl_muldiv #(
        .W    (W),
        .ITER (ITER)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .is_div (bus.req_op != OP_MUL),
        .a      (bus.req_a),
        .b      (bus.req_b),
        .busy   (md_busy),
        .done   (md_done),
        .res_lo (md_lo),
        .res_hi (md_hi)
    );

    assign unused_alu_vc  = bus.alu_ccr[1:0];
    assign unused_md_busy = md_busy;

    always_comb begin
        x_data          = '0;
        x_hi            = '0;
        x_v             = 1'b0;
        x_err           = 1'b0;
        x_use_alu_flags = 1'b0;
        c_nxt           = carry;
        sum17           = {1'b0, a_q} + {1'b0, b_q};
        dif17           = {1'b0, a_q} - {1'b0, b_q};
        if (state == ST_ITER) begin
            case (op_q)
                OP_MUL: begin
                    x_data = md_lo;
                    x_hi   = md_hi;
                    x_v    = (md_hi != '0);
                end
                OP_DIV: begin
                    x_data = md_lo;
                    x_hi   = md_hi;
                end
                default: x_data = md_hi;
            endcase
        end else begin
            case (op_q)
                OP_NOP_A, OP_NOP_B, OP_NOT_A, OP_AND, OP_OR, OP_XOR: begin
                    x_data          = bus.alu_res;
                    x_use_alu_flags = 1'b1;
                end
                OP_ADD: begin
                    x_data = sum17[W-1:0];
                    c_nxt  = sum17[W];
                    x_v    = (a_q[W-1] == b_q[W-1]) && (sum17[W-1] != a_q[W-1]);
                end
                OP_SUB: begin
                    x_data = dif17[W-1:0];
                    c_nxt  = dif17[W];
                    x_v    = (a_q[W-1] != b_q[W-1]) && (dif17[W-1] != a_q[W-1]);
                end
                OP_MUL: x_data = '0;
                // Only a zero divisor reaches EXEC for div/mod.
                OP_DIV: begin
                    x_data = '1;
                    x_v    = 1'b1;
                    x_err  = 1'b1;
                end
                OP_MOD: begin
                    x_data = a_q;
                    x_v    = 1'b1;
                    x_err  = 1'b1;
                end
                OP_CLR_C: begin
                    x_data = a_q;
                    c_nxt  = 1'b0;
                end
                OP_SET_C: begin
                    x_data = a_q;
                    c_nxt  = 1'b1;
                end
                default: x_err = 1'b1;
            endcase
        end
        x_ccr        = '0;
        x_ccr[CCR_N] = x_use_alu_flags ? bus.alu_ccr[CCR_N] : x_data[W-1];
        x_ccr[CCR_Z] = x_use_alu_flags ? bus.alu_ccr[CCR_Z] : (x_data == '0);
        x_ccr[CCR_V] = x_v;
        x_ccr[CCR_C] = c_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= OP_NOP_A;
            a_q         <= '0;
            b_q         <= '0;
            carry       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_hi_q    <= '0;
            rsp_ccr_q   <= '0;
            rsp_err_q   <= 1'b0;
            alu_op_q    <= OP_NOP_A;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q <= bus.req_op;
                        a_q  <= bus.req_a;
                        b_q  <= bus.req_b;
                        if (is_alu_op(bus.req_op)) begin
                            alu_op_q <= bus.req_op;
                            alu_a_q  <= bus.req_a;
                            alu_b_q  <= bus.req_b;
                        end
                        state <= iter_start ? ST_ITER : ST_EXEC;
                    end
                end
                ST_EXEC, ST_ITER: begin
                    if ((state == ST_EXEC) || md_done) begin
                        rsp_data_q  <= x_data;
                        rsp_hi_q    <= x_hi;
                        rsp_ccr_q   <= x_ccr;
                        rsp_err_q   <= x_err;
                        carry       <= c_nxt;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_hi    = rsp_hi_q;
    assign bus.rsp_ccr   = rsp_ccr_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;

`ifdef ALU_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops  <= '0;
            perf_busy <= '0;
        end else begin
            if (rsp_valid_q && bus.rsp_ready) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (state != ST_IDLE) begin
                perf_busy <= perf_busy + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - vector table, randomized model comparison and reset/backpressure sequences for alu_ctrl
module tb_alu_ctrl;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic [15:0] hi;
        logic [3:0]  ccr;
        logic        err;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic model_c = 1'b0;

    alu_ctrl_if #(.W(16)) bus();

`ifdef ALU_CTRL_PERF_CNT_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_busy;
`endif

    alu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave)
`ifdef ALU_CTRL_PERF_CNT_EN
        ,
        .perf_ops  (perf_ops),
        .perf_busy (perf_busy)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU.
    logic [15:0] alu_r;
    always_comb begin
        case (bus.alu_op)
            4'd0:    alu_r = bus.alu_a;
            4'd1:    alu_r = bus.alu_b;
            4'd2:    alu_r = ~bus.alu_a;
            4'd3:    alu_r = bus.alu_a & bus.alu_b;
            4'd4:    alu_r = bus.alu_a | bus.alu_b;
            4'd5:    alu_r = bus.alu_a ^ bus.alu_b;
            default: alu_r = 16'h0000;
        endcase
        bus.alu_res = alu_r;
        bus.alu_ccr = {alu_r[15], alu_r == 16'h0000, 2'b00};
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] data, input logic [15:0] hi, input logic [3:0] ccr,
                                input logic err, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.data = data; v.hi = hi; v.ccr = ccr; v.err = err; v.lat = lat;
        return v;
    endfunction

    // Reference: plain arithmetic on the operation's rules.
    function automatic vec_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic c_in);
        vec_t        e;
        logic [16:0] s;
        logic [31:0] p;
        int          sa;
        int          sb;
        int          r;
        logic        v;
        logic        c;
        e.op = op; e.a = a; e.b = b; e.hi = 16'h0; e.err = 1'b0; e.data = 16'h0;
        v = 1'b0; c = c_in;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            4'd0: e.data = a;
            4'd1: e.data = b;
            4'd2: e.data = ~a;
            4'd3: e.data = a & b;
            4'd4: e.data = a | b;
            4'd5: e.data = a ^ b;
            4'd6: begin
                s = {1'b0, a} + {1'b0, b};
                e.data = s[15:0]; c = s[16];
                r = sa + sb; v = (r > 32767) || (r < -32768);
            end
            4'd7: begin
                e.data = a - b; c = (a < b);
                r = sa - sb; v = (r > 32767) || (r < -32768);
            end
            4'd8: begin
                p = {16'h0, a} * {16'h0, b};
                e.data = p[15:0]; e.hi = p[31:16]; v = (e.hi != 16'h0);
            end
            4'd9: begin
                if (b == 16'h0) begin e.data = 16'hFFFF; e.err = 1'b1; v = 1'b1; end
                else begin e.data = a / b; e.hi = a % b; end
            end
            4'd10: begin
                if (b == 16'h0) begin e.data = a; e.err = 1'b1; v = 1'b1; end
                else e.data = a % b;
            end
            4'd11: begin e.data = a; c = 1'b0; end
            4'd12: begin e.data = a; c = 1'b1; end
            default: e.err = 1'b1;
        endcase
        e.ccr = {e.data[15], e.data == 16'h0, v, c};
        e.lat = ((op == 4'd8 || op == 4'd9 || op == 4'd10) && b != 16'h0) ? 17 : 2;
        return e;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output vec_t r, output logic [3:0] ex_op, output logic [15:0] ex_a);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        r.lat = 1;
        ex_op = bus.alu_op;
        ex_a  = bus.alu_a;
        while (!bus.rsp_valid && r.lat < 40) begin
            @(posedge clk); #1;
            r.lat++;
        end
        r.op = op; r.a = a; r.b = b;
        r.data = bus.rsp_data; r.hi = bus.rsp_hi; r.ccr = bus.rsp_ccr; r.err = bus.rsp_err;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic compare(input string tag, input vec_t got, input vec_t exp,
                           input logic [3:0] ex_op, input logic [15:0] ex_a);
        check({tag, "_data"}, 32'(got.data), 32'(exp.data));
        check({tag, "_hi"},   32'(got.hi),   32'(exp.hi));
        check({tag, "_ccr"},  32'(got.ccr),  32'(exp.ccr));
        check({tag, "_err"},  32'(got.err),  32'(exp.err));
        check({tag, "_lat"},  32'(got.lat),  32'(exp.lat));
        if (exp.op <= 4'd5) begin
            check({tag, "_alu_op"}, 32'(ex_op), 32'(exp.op));
            check({tag, "_alu_a"},  32'(ex_a),  32'(exp.a));
        end
    endtask

    vec_t        vecs[19];
    vec_t        got;
    vec_t        exp;
    logic [3:0]  ex_op;
    logic [15:0] ex_a;
    logic [22:0] snap;
    logic [15:0] snap_hi;
    logic [3:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;
    int          n;
    int          spurious;

    initial begin
        vecs[0]  = mk(4'b0101, 16'h00FF, 16'h0F0F, 16'h0FF0, 16'h0000, 4'b0000, 1'b0, 2);
        vecs[1]  = mk(4'b0110, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b1010, 1'b0, 2);
        vecs[2]  = mk(4'b0111, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 4'b1001, 1'b0, 2);
        vecs[3]  = mk(4'b1011, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 1'b0, 2);
        vecs[4]  = mk(4'b1000, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0010, 1'b0, 17);
        vecs[5]  = mk(4'b1001, 16'd100,  16'd7,    16'h000E, 16'h0002, 4'b0000, 1'b0, 17);
        vecs[6]  = mk(4'b1010, 16'd100,  16'd7,    16'h0002, 16'h0000, 4'b0000, 1'b0, 17);
        vecs[7]  = mk(4'b1001, 16'd5,    16'd0,    16'hFFFF, 16'h0000, 4'b1010, 1'b1, 2);
        vecs[8]  = mk(4'b1100, 16'h8001, 16'h0000, 16'h8001, 16'h0000, 4'b1001, 1'b0, 2);
        vecs[9]  = mk(4'b0101, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'b0101, 1'b0, 2);
        vecs[10] = mk(4'b1011, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 1'b0, 2);
        vecs[11] = mk(4'b1101, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 4'b0100, 1'b1, 2);
        vecs[12] = mk(4'b1100, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 4'b0001, 1'b0, 2);
        vecs[13] = mk(4'b1111, 16'hABCD, 16'h0001, 16'h0000, 16'h0000, 4'b0101, 1'b1, 2);
        vecs[14] = mk(4'b1010, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 4'b0011, 1'b1, 2);
        vecs[15] = mk(4'b1000, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0011, 1'b0, 17);
        vecs[16] = mk(4'b1000, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 4'b0101, 1'b0, 2);
        vecs[17] = mk(4'b0010, 16'h00FF, 16'h0000, 16'hFF00, 16'h0000, 4'b1001, 1'b0, 2);
        vecs[18] = mk(4'b0110, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b0101, 1'b0, 2);

        bus.req_valid = 1'b0; bus.req_op = 4'h0; bus.req_a = 16'h0; bus.req_b = 16'h0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_bus", {bus.rsp_err, bus.rsp_ccr, bus.rsp_hi, bus.rsp_data}, 32'd0);
        check("rst_alu", {bus.alu_op, bus.alu_a, bus.alu_b[11:0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, got, ex_op, ex_a);
            compare($sformatf("vec%0d", i), got, vecs[i], ex_op, ex_a);
            model_c = vecs[i].ccr[0];
        end

        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom >> $urandom_range(0, 14));
            exp = model(rop, ra, rb, model_c);
            run_op(rop, ra, rb, got, ex_op, ex_a);
            compare($sformatf("rnd%0d_op%0h", i, rop), got, exp, ex_op, ex_a);
            model_c = exp.ccr[0];
        end

        // Reset during the fifth ITER cycle of a multiply discards it.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 4'b1000; bus.req_a = 16'h1234; bus.req_b = 16'h0100;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        check("midrst_rsp_bus", {bus.rsp_err, bus.rsp_ccr, bus.rsp_hi[10:0], bus.rsp_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_c = 1'b0;
        spurious = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) spurious++;
        end
        check("midrst_no_rsp", 32'(spurious), 32'd0);

        // Backpressure: response held for 10 cycles with rsp_ready low.
        exp = model(4'b0111, 16'h0005, 16'h0003, model_c);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 4'b0111; bus.req_a = 16'h0005; bus.req_b = 16'h0003;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_lat", 32'(n), 32'd2);
        check("bp_data", 32'(bus.rsp_data), 32'(exp.data));
        check("bp_ccr", 32'(bus.rsp_ccr), 32'(exp.ccr));
        snap    = {bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_ccr, bus.rsp_data};
        snap_hi = bus.rsp_hi;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", i),
                  32'({bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_ccr, bus.rsp_data}),
                  32'({1'b1, 1'b0, exp.err, exp.ccr, exp.data}));
            check($sformatf("bp_hold_hi%0d", i), 32'(bus.rsp_hi), 32'(snap_hi));
        end
        check("bp_snap", 32'(snap), 32'({1'b1, 1'b0, exp.err, exp.ccr, exp.data}));
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("bp_release", 32'({bus.rsp_valid, bus.req_ready}), 32'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
